regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single register-file write port among NREQ writeback requesters (ALU, LSU, MDU).
//   Round-robin arbitration with a valid/ready handshake per requester.
//   One registered writeback stage drives the regfile write port (wen/index_rd/data_rd).
//   Optional bypass covers the one-cycle window before a staged write lands in the regfile.
// PARAMETERS
//   NREQ    3    number of writeback requesters (2..8); index 0 = ALU, 1 = LSU, 2 = MDU
//   XLEN    64   data width
//   REG_AW  5    register index width
// PORTS
//   clk            in   1            clock, rising edge
//   rstn           in   1            asynchronous active-low reset
//   req_valid      in   NREQ         requester i has a write pending
//   req_ready      out  NREQ         requester i granted this cycle
//   req_rd         in   NREQ*REG_AW  destination index, requester i at bits [i*REG_AW +: REG_AW]
//   req_data       in   NREQ*XLEN    write data, requester i at bits [i*XLEN +: XLEN]
//   wb_wen         out  1            to regfile wen
//   wb_rd          out  REG_AW       to regfile index_rd
//   wb_data        out  XLEN         to regfile data_rd
//   byp_rs1_idx    in   REG_AW       consumer read index 1
//   byp_rs1_hit    out  1            staged write matches byp_rs1_idx
//   byp_rs1_data   out  XLEN         forwarded data for rs1
//   byp_rs2_idx    in   REG_AW       consumer read index 2
//   byp_rs2_hit    out  1            staged write matches byp_rs2_idx
//   byp_rs2_data   out  XLEN         forwarded data for rs2
// BEHAVIOUR
//   - Reset (async, rstn=0): wb_wen=0, wb_rd=0, wb_data=0, rr_ptr=NREQ-1 (requester 0 wins first);
//     req_ready=0 while rstn=0. A staged write in flight is dropped; no regfile write occurs.
//   - Arbitration (combinational): search from (rr_ptr+1) mod NREQ upward, wrap to 0; first valid wins.
//     grant one-hot or zero; req_ready = grant. At most one ready per cycle.
//   - Transfer when req_valid[i] & req_ready[i]. Requester holds valid, rd and data stable until ready;
//     valid never drops without a transfer.
//   - On transfer (edge ending cycle N): wb_rd<=rd, wb_data<=data, wb_wen<=(rd!=0), rr_ptr<=i.
//     rd==0: accepted, pointer rotates, wb_wen=0 (x0 never written).
//   - No transfer: wb_wen<=0; wb_rd, wb_data, rr_ptr hold.
//   - Latency: accepted in cycle N -> wb_wen high in cycle N+1 -> regfile updated at end of N+1.
//   - Back-to-back: one write per cycle sustained; write port never stalls.
//   - Fairness: continuously-valid requester granted within NREQ cycles.
//   - All valid after reset: grant order 0,1,2,0,...
//   - Same rd from two requesters in consecutive cycles: both written in grant order; later wins.
// CONFIGURATION
//   REGFILE_WB_BYPASS_EN defined:
//     byp_rsX_hit  = wb_wen & (wb_rd == byp_rsX_idx) & (byp_rsX_idx != 0)
//     byp_rsX_data = hit ? wb_data : 0
//     Combinational; reset value 0.
//   Undefined: ports kept; byp_rsX_hit and byp_rsX_data tied to 0.
// STRUCTURE
//   - XLEN and REG_AW defaults, and requester ID localparams (ALU/LSU/MDU), live in the shared
//     header default.v.
//   - Sub-module rr_arbiter (params N; in valid[N], ptr; out grant[N], gidx):
//     pure combinational rotate-and-pick.
//   - Writeback stage and rr_ptr built from the common dff (enable, async reset) cells.
// TESTING
//   1. Reset, req_valid=3'b111, rd=1/2/3, data=A/B/C held
//      -> ready order 0,1,2,0; wb_wen=1 each cycle; wb_rd 1,2,3,1; wb_data matches one cycle later.
//   2. Only LSU valid, rd=5, data=64'hDEAD_BEEF
//      -> ready[1] same cycle; next cycle wb_wen=1, wb_rd=5, wb_data=DEAD_BEEF; then wb_wen=0.
//   3. ALU request rd=0, data=FFFF
//      -> ready[0]=1, wb_wen stays 0, rr_ptr=0 (next tie goes to LSU).
//   4. rstn pulled low mid-cycle with a staged write (wb_wen=1)
//      -> wb_wen=0 immediately, ready=0; after release first grant goes to requester 0.
//   5. BYPASS_EN: stage holds rd=7, data=0x42; byp_rs1_idx=7, byp_rs2_idx=0
//      -> rs1_hit=1, rs1_data=0x42, rs2_hit=0. Macro off -> both hits 0.
//   6. Random valid/stall with scoreboard model
//      -> no lost or duplicated writes; starvation bound NREQ holds; one-hot ready.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared defaults and requester IDs for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

   localparam int unsigned XLEN_DEF   = 64;
   localparam int unsigned REG_AW_DEF = 5;

   // Requester slot assignment on the writeback port
   localparam int unsigned REQ_ALU = 0;
   localparam int unsigned REQ_LSU = 1;
   localparam int unsigned REQ_MDU = 2;

   // Width of a requester index / round-robin pointer; never zero
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin pick: searches upward from ptr+1 (mod N) and
// grants the first valid requester. grant is one-hot or zero.
module rr_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned N = 3
) (
   input  logic [N-1:0]          valid,
   input  logic [idx_w(N)-1:0]   ptr,
   output logic [N-1:0]          grant,
   output logic [idx_w(N)-1:0]   gidx
);

   localparam int unsigned PW = idx_w(N);

   // Rotate-and-pick: first valid requester after the last winner
   always_comb begin
      logic found;
      int   idx;
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= int'(N); k++) begin
         idx = (int'(ptr) + k) % int'(N);
         if (!found && valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            gidx       = PW'(idx);
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin sharing of the single write
// port among NREQ requesters, one registered writeback stage.
// Optional feature: define REGFILE_WB_BYPASS_EN to forward the staged write
// to the two consumer read ports; otherwise the bypass outputs are tied to 0.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned NREQ   = 3,
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned REG_AW = REG_AW_DEF
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*REG_AW-1:0]   req_rd,
   input  logic [NREQ*XLEN-1:0]     req_data,
   output logic                     wb_wen,
   output logic [REG_AW-1:0]        wb_rd,
   output logic [XLEN-1:0]          wb_data,
   input  logic [REG_AW-1:0]        byp_rs1_idx,
   output logic                     byp_rs1_hit,
   output logic [XLEN-1:0]          byp_rs1_data,
   input  logic [REG_AW-1:0]        byp_rs2_idx,
   output logic                     byp_rs2_hit,
   output logic [XLEN-1:0]          byp_rs2_data
);

   localparam int unsigned PW = idx_w(NREQ);

   logic [NREQ-1:0]   grant;
   logic [PW-1:0]     gidx;
   logic              xfer;
   logic [REG_AW-1:0] sel_rd;
   logic [XLEN-1:0]   sel_data;

   logic              wb_wen_q, wb_wen_d;
   logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]   wb_data_q, wb_data_d;
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;

   rr_arbiter #(
      .N (NREQ)
   ) u_rr_arbiter (
      .valid (req_valid),
      .ptr   (rr_ptr_q),
      .grant (grant),
      .gidx  (gidx)
   );

   // Ready is the grant, forced low while reset is asserted
   always_comb begin
      req_ready = rstn ? grant : '0;
      xfer      = rstn & (|grant);
   end

   // One-hot grant selects the winner's index and data
   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (grant[i]) begin
            sel_rd   = sel_rd   | req_rd[i*REG_AW +: REG_AW];
            sel_data = sel_data | req_data[i*XLEN +: XLEN];
         end
      end
   end

   // Next state of the writeback stage and round-robin pointer
   always_comb begin
      wb_wen_d  = 1'b0;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      rr_ptr_d  = rr_ptr_q;
      if (xfer) begin
         // rd==0 is accepted and rotates the pointer but never writes x0
         wb_wen_d  = (sel_rd != '0);
         wb_rd_d   = sel_rd;
         wb_data_d = sel_data;
         rr_ptr_d  = gidx;
      end
   end

   // Stage registers; reset drops any write in flight
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wb_wen_q  <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
         rr_ptr_q  <= PW'(NREQ - 1);
      end else begin
         wb_wen_q  <= wb_wen_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   // Drive the regfile write port from the stage
   always_comb begin
      wb_wen  = wb_wen_q;
      wb_rd   = wb_rd_q;
      wb_data = wb_data_q;
   end

`ifdef REGFILE_WB_BYPASS_EN
   // Forward the staged write during the cycle before it lands in the regfile
   always_comb begin
      byp_rs1_hit  = wb_wen_q && (wb_rd_q == byp_rs1_idx) && (byp_rs1_idx != '0);
      byp_rs2_hit  = wb_wen_q && (wb_rd_q == byp_rs2_idx) && (byp_rs2_idx != '0);
      byp_rs1_data = byp_rs1_hit ? wb_data_q : '0;
      byp_rs2_data = byp_rs2_hit ? wb_data_q : '0;
   end
`else
   logic unused_byp_idx;

   // Bypass disabled: ports kept, outputs tied off
   always_comb begin
      unused_byp_idx = ^{byp_rs1_idx, byp_rs2_idx};
      byp_rs1_hit    = 1'b0;
      byp_rs2_hit    = 1'b0;
      byp_rs1_data   = '0;
      byp_rs2_data   = '0;
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed + randomized self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

   localparam int NREQ = 3;
   localparam int XLEN = 64;
   localparam int AW   = 5;

   logic                 clk;
   logic                 rstn;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*AW-1:0]   req_rd;
   logic [NREQ*XLEN-1:0] req_data;
   logic                 wb_wen;
   logic [AW-1:0]        wb_rd;
   logic [XLEN-1:0]      wb_data;
   logic [AW-1:0]        byp_rs1_idx;
   logic                 byp_rs1_hit;
   logic [XLEN-1:0]      byp_rs1_data;
   logic [AW-1:0]        byp_rs2_idx;
   logic                 byp_rs2_hit;
   logic [XLEN-1:0]      byp_rs2_data;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_wb_arbiter #(
      .NREQ   (NREQ),
      .XLEN   (XLEN),
      .REG_AW (AW)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_rd       (req_rd),
      .req_data     (req_data),
      .wb_wen       (wb_wen),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .byp_rs1_idx  (byp_rs1_idx),
      .byp_rs1_hit  (byp_rs1_hit),
      .byp_rs1_data (byp_rs1_data),
      .byp_rs2_idx  (byp_rs2_idx),
      .byp_rs2_hit  (byp_rs2_hit),
      .byp_rs2_data (byp_rs2_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
      req_rd[i*AW +: AW]       = rd;
      req_data[i*XLEN +: XLEN] = data;
   endtask

   localparam logic [XLEN-1:0] DA = 64'hAAAA_0000_0000_000A;
   localparam logic [XLEN-1:0] DB = 64'hBBBB_0000_0000_000B;
   localparam logic [XLEN-1:0] DC = 64'hCCCC_0000_0000_000C;

   // Random-phase model state
   logic            pv    [NREQ];
   logic [AW-1:0]   prd   [NREQ];
   logic [XLEN-1:0] pdata [NREQ];
   int              pwait [NREQ];

   initial begin
      logic [XLEN-1:0] dtab [3];
      int              mp;
      int              eg;
      logic [AW-1:0]   erd;
      logic [XLEN-1:0] edata;
      logic [NREQ-1:0] exp_ready;

      dtab[0] = DA;
      dtab[1] = DB;
      dtab[2] = DC;

      // 1. Reset, then all valid -> grants 0,1,2,0
      rstn        = 1'b0;
      req_valid   = 3'b111;
      req_rd      = '0;
      req_data    = '0;
      byp_rs1_idx = '0;
      byp_rs2_idx = '0;
      set_req(0, 5'd1, DA);
      set_req(1, 5'd2, DB);
      set_req(2, 5'd3, DC);
      #3;
      check_eq("rst_ready", 64'(req_ready), 64'd0);
      check_eq("rst_wen", 64'(wb_wen), 64'd0);
      check_eq("rst_rd", 64'(wb_rd), 64'd0);
      check_eq("rst_data", wb_data, 64'd0);
      tick();
      tick();
      check_eq("rst_hold_wen", 64'(wb_wen), 64'd0);
      check_eq("rst_hold_ready", 64'(req_ready), 64'd0);
      rstn = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         int e;
         e = k % 3;
         check_eq("t1_ready", 64'(req_ready), 64'(3'b001 << e));
         tick();
         check_eq("t1_wen", 64'(wb_wen), 64'd1);
         check_eq("t1_rd", 64'(wb_rd), 64'(e + 1));
         check_eq("t1_data", wb_data, dtab[e]);
         #1;
      end

      // 2. Only LSU valid (pointer at 0)
      req_valid = 3'b010;
      set_req(1, 5'd5, 64'hDEAD_BEEF);
      #1;
      check_eq("t2_ready", 64'(req_ready), 64'b010);
      tick();
      check_eq("t2_wen", 64'(wb_wen), 64'd1);
      check_eq("t2_rd", 64'(wb_rd), 64'd5);
      check_eq("t2_data", wb_data, 64'hDEAD_BEEF);
      req_valid = 3'b000;
      #1;
      check_eq("t2_idle_ready", 64'(req_ready), 64'd0);
      tick();
      check_eq("t2_idle_wen", 64'(wb_wen), 64'd0);
      check_eq("t2_idle_rd_hold", 64'(wb_rd), 64'd5);
      check_eq("t2_idle_data_hold", wb_data, 64'hDEAD_BEEF);

      // 3. ALU writes x0 (pointer at 1): accepted, no write, pointer -> 0
      req_valid = 3'b001;
      set_req(0, 5'd0, 64'hFFFF);
      #1;
      check_eq("t3_ready", 64'(req_ready), 64'b001);
      tick();
      check_eq("t3_wen", 64'(wb_wen), 64'd0);
      check_eq("t3_rd", 64'(wb_rd), 64'd0);
      check_eq("t3_data", wb_data, 64'hFFFF);
      set_req(0, 5'd1, DA);
      set_req(1, 5'd2, DB);
      req_valid = 3'b111;
      #1;
      check_eq("t3_tie_lsu", 64'(req_ready), 64'b010);
      tick();
      check_eq("t3_tie_wen", 64'(wb_wen), 64'd1);
      check_eq("t3_tie_rd", 64'(wb_rd), 64'd2);

      // 4. Async reset with a staged write
      #3;
      rstn = 1'b0;
      #1;
      check_eq("t4_wen", 64'(wb_wen), 64'd0);
      check_eq("t4_rd", 64'(wb_rd), 64'd0);
      check_eq("t4_data", wb_data, 64'd0);
      check_eq("t4_ready", 64'(req_ready), 64'd0);
      tick();
      rstn = 1'b1;
      #1;
      check_eq("t4_first_grant", 64'(req_ready), 64'b001);
      tick();
      check_eq("t4_post_wen", 64'(wb_wen), 64'd1);
      check_eq("t4_post_rd", 64'(wb_rd), 64'd1);
      check_eq("t4_post_data", wb_data, DA);

      // 5. Bypass with stage holding rd=7, data=0x42 (pointer at 0)
      req_valid = 3'b001;
      set_req(0, 5'd7, 64'h42);
      #1;
      check_eq("t5_ready", 64'(req_ready), 64'b001);
      tick();
      req_valid   = 3'b000;
      byp_rs1_idx = 5'd7;
      byp_rs2_idx = 5'd0;
      #1;
      check_eq("t5_stage_rd", 64'(wb_rd), 64'd7);
`ifdef REGFILE_WB_BYPASS_EN
      check_eq("t5_rs1_hit", 64'(byp_rs1_hit), 64'd1);
      check_eq("t5_rs1_data", byp_rs1_data, 64'h42);
`else
      check_eq("t5_rs1_hit", 64'(byp_rs1_hit), 64'd0);
      check_eq("t5_rs1_data", byp_rs1_data, 64'd0);
`endif
      check_eq("t5_rs2_hit", 64'(byp_rs2_hit), 64'd0);
      check_eq("t5_rs2_data", byp_rs2_data, 64'd0);
      tick();
      check_eq("t5_idle_rs1_hit", 64'(byp_rs1_hit), 64'd0);
      check_eq("t5_idle_rs1_data", byp_rs1_data, 64'd0);
      byp_rs1_idx = '0;

      // 6. Random valid/stall against a scoreboard model (pointer at 0)
      mp = 0;
      for (int i = 0; i < NREQ; i++) begin
         pv[i]    = 1'b0;
         prd[i]   = '0;
         pdata[i] = '0;
         pwait[i] = 0;
      end
      for (int cyc = 0; cyc < 300; cyc++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pv[i] && ($urandom_range(0, 2) != 0)) begin
               pv[i]    = 1'b1;
               prd[i]   = AW'($urandom_range(0, 31));
               pdata[i] = {$urandom, $urandom};
               pwait[i] = 0;
            end
            req_valid[i] = pv[i];
            set_req(i, prd[i], pdata[i]);
         end
         #1;
         eg = -1;
         for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (mp + k) % NREQ;
            if (eg < 0 && pv[j]) eg = j;
         end
         exp_ready = (eg >= 0) ? NREQ'(1 << eg) : '0;
         check_eq("rnd_ready", 64'(req_ready), 64'(exp_ready));
         erd   = '0;
         edata = '0;
         if (eg >= 0) begin
            check_eq("rnd_starve", 64'(pwait[eg] < NREQ), 64'd1);
            erd   = prd[eg];
            edata = pdata[eg];
            for (int i = 0; i < NREQ; i++) begin
               if (pv[i] && i != eg) pwait[i]++;
            end
            pv[eg] = 1'b0;
            mp     = eg;
         end
         tick();
         if (eg >= 0) begin
            check_eq("rnd_wen", 64'(wb_wen), 64'(erd != '0));
            check_eq("rnd_rd", 64'(wb_rd), 64'(erd));
            check_eq("rnd_data", wb_data, edata);
         end else begin
            check_eq("rnd_idle_wen", 64'(wb_wen), 64'd0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
